// File: rtl/binarysearch_datapath.sv
// rtl/binarysearch_datapath.sv - binary-search datapath: L/R/M/A registers, RAM addressing, F/NF status
module binarysearch_datapath #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_L,
    input  logic              set_R,
    input  logic              set_M,
    input  logic              load_A,
    input  logic [DATA_W-1:0] A_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              F,
    output logic              NF,
    output logic              found,
    output logic              not_found,
    output logic [ADDR_W-1:0] loc
);
    localparam logic [3:0] CMD_INIT    = 4'b1110;
    localparam logic [3:0] CMD_FETCH   = 4'b0001;
    localparam logic [3:0] CMD_COMPARE = 4'b0111;
    localparam logic [ADDR_W-1:0] TOP  = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] l, r, m;
    logic [DATA_W-1:0] a;
    logic [ADDR_W:0]   sum;
    logic [ADDR_W-1:0] mid;
    logic [3:0]        cmd;
    logic              match, key_below;

    assign cmd       = {load_A, set_L, set_R, set_M};
    assign sum       = {1'b0, l} + {1'b0, r};
    assign mid       = sum[ADDR_W:1];
    assign match     = (mem_rdata == a);
    assign key_below = (a < mem_rdata);

    always_comb begin
        F        = 1'b0;
        NF       = 1'b0;
        mem_addr = m;
        case (cmd)
            CMD_FETCH: mem_addr = mid;
            CMD_COMPARE: begin
                // Edge checks stand in for M-1 / M+1 so L and R never wrap.
                if (match)          F  = 1'b1;
                else if (key_below) NF = (m == l);
                else                NF = (m == r);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            l         <= '0;
            r         <= TOP;
            m         <= '0;
            a         <= '0;
            found     <= 1'b0;
            not_found <= 1'b0;
            loc       <= '0;
        end else begin
            case (cmd)
                CMD_INIT: begin
                    a         <= A_in;
                    l         <= '0;
                    r         <= TOP;
                    found     <= 1'b0;
                    not_found <= 1'b0;
                    loc       <= '0;
                end
                CMD_FETCH: m <= mid;
                CMD_COMPARE: begin
                    if (match) begin
                        found <= 1'b1;
                        loc   <= m;
                    end else if (key_below) begin
                        if (m == l) not_found <= 1'b1;
                        else        r <= m - 1'b1;
                    end else begin
                        if (m == r) not_found <= 1'b1;
                        else        l <= m + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_binarysearch_datapath.sv
// tb/tb_binarysearch_datapath.sv - directed bench for binarysearch_datapath against a mem[i]=2*i+1 RAM model
module tb_binarysearch_datapath;
    logic       clock = 1'b0;
    logic       reset;
    logic       set_L, set_R, set_M, load_A;
    logic [7:0] A_in;
    logic [7:0] mem_rdata;
    logic [4:0] mem_addr;
    logic       F, NF, found, not_found;
    logic [4:0] loc;

    int tests = 0;
    int fails = 0;

    binarysearch_datapath #(.ADDR_W(5), .DATA_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .set_L     (set_L),
        .set_R     (set_R),
        .set_M     (set_M),
        .load_A    (load_A),
        .A_in      (A_in),
        .mem_rdata (mem_rdata),
        .mem_addr  (mem_addr),
        .F         (F),
        .NF        (NF),
        .found     (found),
        .not_found (not_found),
        .loc       (loc)
    );

    always #5 clock = ~clock;

    // Sorted RAM with one-cycle read latency
    always @(posedge clock) mem_rdata <= 8'(2 * int'(mem_addr) + 1);

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c);
        @(negedge clock);
        {load_A, set_L, set_R, set_M} = c;
        #1;
    endtask

    task automatic run_search(input string name, input logic [7:0] key, input int exp_probes[$],
                              input bit exp_found, input int exp_loc);
        int  n = 0;
        bit  done = 1'b0;
        bit  f_last = 1'b0;
        bit  nf_last = 1'b0;
        A_in = key;
        drive(4'b1110);
        while (!done && n < 8) begin
            drive(4'b0001);
            if (n < exp_probes.size())
                check($sformatf("%s probe%0d", name, n), int'(mem_addr), exp_probes[n]);
            n++;
            drive(4'b0111);
            check($sformatf("%s F&NF", name), int'(F & NF), 0);
            f_last  = F;
            nf_last = NF;
            if (F || NF) done = 1'b1;
        end
        check({name, " probes"}, n, exp_probes.size());
        check({name, " last F"}, int'(f_last), int'(exp_found));
        check({name, " last NF"}, int'(nf_last), int'(!exp_found));
        drive(4'b0000);
        check({name, " found"}, int'(found), int'(exp_found));
        check({name, " not_found"}, int'(not_found), int'(!exp_found));
        check({name, " loc"}, int'(loc), exp_found ? exp_loc : 0);
        check({name, " idle F"}, int'(F), 0);
    endtask

    initial begin
        int q[$];
        reset = 1'b1;
        {load_A, set_L, set_R, set_M} = 4'b0000;
        A_in = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst F", int'(F), 0);
        check("rst NF", int'(NF), 0);
        check("rst mem_addr", int'(mem_addr), 0);
        check("rst found", int'(found), 0);
        check("rst not_found", int'(not_found), 0);
        check("rst loc", int'(loc), 0);

        q = '{15, 23, 19, 17, 16};
        run_search("a33", 8'd33, q, 1'b1, 16);
        q = '{15, 7, 3, 1, 0};
        run_search("a1", 8'd1, q, 1'b1, 0);
        q = '{15, 23, 27, 29, 30, 31};
        run_search("a63", 8'd63, q, 1'b1, 31);
        q = '{15, 7, 3, 1, 0};
        run_search("a0", 8'd0, q, 1'b0, 0);
        check("a0 L", int'(dut.l), 0);
        q = '{15, 23, 19, 17, 16};
        run_search("a32", 8'd32, q, 1'b0, 0);
        q = '{15, 23, 27, 29, 30, 31};
        run_search("a64", 8'd64, q, 1'b0, 0);
        check("a64 R", int'(dut.r), 31);

        // Abort after the second compare of a fresh search
        A_in = 8'd33;
        drive(4'b1110);
        drive(4'b0001);
        drive(4'b0111);
        drive(4'b0001);
        drive(4'b0111);
        @(negedge clock);
        reset = 1'b1;
        {load_A, set_L, set_R, set_M} = 4'b0000;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("abort L", int'(dut.l), 0);
        check("abort R", int'(dut.r), 31);
        check("abort found", int'(found), 0);
        check("abort not_found", int'(not_found), 0);
        check("abort F", int'(F), 0);
        check("abort NF", int'(NF), 0);

        q = '{15, 23, 19, 17, 16};
        run_search("hold", 8'd33, q, 1'b1, 16);
        for (int i = 0; i < 10; i++) begin
            drive(4'b0000);
            check($sformatf("idle%0d loc", i), int'(loc), 16);
            check($sformatf("idle%0d found", i), int'(found), 1);
            check($sformatf("idle%0d F", i), int'(F), 0);
            check($sformatf("idle%0d addr", i), int'(mem_addr), 16);
        end
        drive(4'b1111);
        check("illegal F", int'(F), 0);
        check("illegal NF", int'(NF), 0);
        drive(4'b0000);
        check("illegal L", int'(dut.l), 16);
        check("illegal R", int'(dut.r), 16);
        check("illegal M", int'(dut.m), 16);
        check("illegal loc", int'(loc), 16);
        check("illegal found", int'(found), 1);

        A_in = 8'd5;
        drive(4'b1110);
        drive(4'b0000);
        check("reinit found", int'(found), 0);
        check("reinit not_found", int'(not_found), 0);
        check("reinit loc", int'(loc), 0);
        check("reinit R", int'(dut.r), 31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/binarysearch_datapath.md
Name: binarysearch_datapath

Overview:
- Datapath partner of the binary-search controller. It executes the controller's set_L/set_R/set_M/load_A strobes against a sorted synchronous RAM and returns the F (found) and NF (not found) status the controller branches on.
- Owns the L, R, M and A registers, drives the RAM read address and holds the search result until the next search starts.
- Sits between the controller FSM and a 1-cycle-latency read port of an ascending-sorted RAM.

Parameters:
ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W.
DATA_W, 8, width of the RAM word and of the search key.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
set_L  in  1  controller strobe
set_R  in  1  controller strobe
set_M  in  1  controller strobe
load_A  in  1  controller strobe
A_in  in  DATA_W  search key, sampled on the init command
mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_addr is sampled
mem_addr  out  ADDR_W  RAM read address
F  out  1  combinational: key matched this compare cycle
NF  out  1  combinational: search space exhausted this compare cycle
found  out  1  registered sticky result: key found
not_found  out  1  registered sticky result: key absent
loc  out  ADDR_W  address of the match; valid while found=1

Behaviour:
- Interface: reset is synchronous and active-high; the clock is clock.
- State registers: L, R, M (ADDR_W bits each), A (DATA_W bits), found, not_found, loc. Sum S = L+R is computed at ADDR_W+1 bits; mid = S>>1 (floor).
- Reset values: L=0, R=DEPTH-1, M=0, A=0, found=0, not_found=0, loc=0. Outputs after reset: F=0, NF=0, mem_addr=0. Reset mid-search aborts with the same values.
- Command decode on the strobe vector {load_A,set_L,set_R,set_M}. Exact match is required.
- INIT = 1110:
  - A<=A_in, L<=0, R<=DEPTH-1.
  - found<=0, not_found<=0, loc<=0.
- FETCH = 0001:
  - mem_addr = mid (combinational); M<=mid.
  - The RAM samples mem_addr on the same edge, so mem_rdata corresponds to M during the next cycle.
- COMPARE = 0111:
  - mem_addr = M.
  - match = (mem_rdata==A).
  - If match: F=1, NF=0; registers found<=1, loc<=M; L and R hold.
  - Else if A<mem_rdata: if M==L then NF=1, not_found<=1, L/R hold; otherwise R<=M-1.
  - Else (A>mem_rdata): if M==R then NF=1, not_found<=1, L/R hold; otherwise L<=M+1.
  - These M==L and M==R checks replace any signed or underflow arithmetic: R never goes below 0 and L never exceeds DEPTH-1.
- F and NF are asserted only during COMPARE. This lets the controller branch to done in the same cycle. They are never both 1.
- Any other strobe combination (including 0000, the controller's done state) holds all registers, F=NF=0, mem_addr=M.
- Latency per probe is 2 cycles (FETCH then COMPARE); the worst case is ADDR_W+1 probes.
- Unsigned comparison throughout. RAM contents must be strictly ascending; with duplicate values, any matching index is acceptable.
- found and not_found stay asserted through the controller done/idle states until the next INIT or reset.

Test Plan (DEPTH=32, model RAM mem[i]=2*i+1, 1-cycle read latency, controller-sequence driver):
1. INIT A=33, then FETCH/COMPARE loop:
   - mem_addr sequence is 15,23,19,17,16.
   - F=1 on the 5th COMPARE; found=1, loc=16, NF never asserted.
2. A=1 and A=63:
   - found with loc=0 and loc=31 respectively.
   - L/R never wrap; A=63 takes 6 probes (15,23,27,29,30,31).
3. A=0 (below the minimum value):
   - probes 15,7,3,1,0.
   - NF=1 on the 5th COMPARE; not_found=1, found=0, L stays 0.
4. A=32 and A=64:
   - NF=1 on the exhausting compare; not_found=1.
   - For A=64, R stays 31 and the final probe is 31.
5. Reset asserted mid-search after the 2nd COMPARE: next cycle L=0, R=31, found=0, not_found=0, F=NF=0.
6. Hold behaviour:
   - Strobes 0000 for 10 cycles after a find: loc and found unchanged, F=0.
   - An illegal combination (e.g. 1111): no register changes.
   - A new INIT clears found/not_found.
